// File: rtl/hyperbus_txn_ctrl.sv
// hyperbus_txn_ctrl: single-word HyperBus-style transaction controller.
// One 32-bit read or write per request: 6-byte command-address phase,
// LATENCY idle clocks, then 4 data bytes (SDR, one byte per clk).
// Optional macro HB_RWDS_TIMEOUT_EN bounds the read-data wait to TIMEOUT clocks
// and reports an expired wait through rsp_err.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | bus released, req_ready high, waiting for req_valid
// CA     | shifting out the 48-bit command-address word, MSB byte first
// LAT    | initial latency, bus not driven, cs_n held low
// DATA   | write: drive 4 bytes; read: capture bytes strobed by rwds_in
// DONE   | one-cycle response pulse, cs_n high
module hyperbus_txn_ctrl #(
    parameter int LATENCY = 6,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        cs_n,
    output logic [7:0]  dq_out,
    output logic        dq_oe,
    input  logic [7:0]  dq_in,
    output logic        rwds_out,
    output logic        rwds_oe,
    input  logic        rwds_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CA,
        S_LAT,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [4:0] LAT_LOAD = 5'(LATENCY - 1);
`ifdef HB_RWDS_TIMEOUT_EN
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);
`endif

    state_t      r_state;
    logic        r_write;
    logic [39:0] r_ca;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [4:0]  r_cnt;
    logic [1:0]  r_nbyte;
`ifdef HB_RWDS_TIMEOUT_EN
    logic [7:0]  r_tmo;
`endif

    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_cs_n;
    logic [7:0]  r_dq_out;
    logic        r_dq_oe;
    logic        r_rwds_oe;

    logic [47:0] w_ca;
    logic [31:0] w_rdata_next;
    logic        w_rd_last;

    // Command-address word built straight from the request inputs so it can be latched on accept.
    assign w_ca         = {~req_write, 1'b0, 1'b1, req_addr[31:3], 13'd0, req_addr[2:0]};
    assign w_rdata_next = {r_rdata[23:0], dq_in};
    assign w_rd_last    = rwds_in && (r_nbyte == 2'd3);

    // Transaction sequencer; every output is registered and set for the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_ca        <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_cnt       <= '0;
            r_nbyte     <= '0;
`ifdef HB_RWDS_TIMEOUT_EN
            r_tmo       <= '0;
`endif
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cs_n      <= 1'b1;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_rwds_oe   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_write     <= req_write;
                        r_wdata     <= req_wdata;
                        r_ca        <= w_ca[39:0];
                        r_dq_out    <= w_ca[47:40];
                        r_dq_oe     <= 1'b1;
                        r_cs_n      <= 1'b0;
                        r_cnt       <= 5'd5;
                        r_state     <= S_CA;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_CA: begin
                    if (r_cnt == 5'd0) begin
                        r_dq_oe  <= 1'b0;
                        r_dq_out <= '0;
                        r_cnt    <= LAT_LOAD;
                        r_state  <= S_LAT;
                    end else begin
                        r_dq_out <= r_ca[39:32];
                        r_ca     <= {r_ca[31:0], 8'h00};
                        r_cnt    <= r_cnt - 5'd1;
                    end
                end
                S_LAT: begin
                    if (r_cnt == 5'd0) begin
                        r_nbyte <= '0;
                        r_rdata <= '0;
`ifdef HB_RWDS_TIMEOUT_EN
                        r_tmo   <= TMO_LOAD;
`endif
                        if (r_write) begin
                            r_dq_oe   <= 1'b1;
                            r_rwds_oe <= 1'b1;
                            r_dq_out  <= r_wdata[31:24];
                            r_wdata   <= {r_wdata[23:0], 8'h00};
                            r_cnt     <= 5'd3;
                        end
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_DATA: begin
                    if (r_write) begin
                        if (r_cnt == 5'd0) begin
                            r_cs_n      <= 1'b1;
                            r_dq_oe     <= 1'b0;
                            r_rwds_oe   <= 1'b0;
                            r_dq_out    <= '0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b0;
                            r_state     <= S_DONE;
                        end else begin
                            r_dq_out <= r_wdata[31:24];
                            r_wdata  <= {r_wdata[23:0], 8'h00};
                            r_cnt    <= r_cnt - 5'd1;
                        end
                    end else if (w_rd_last) begin
                        // A byte arriving on the final allowed cycle still completes normally.
                        r_cs_n      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rdata_next;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_DONE;
`ifdef HB_RWDS_TIMEOUT_EN
                    end else if (r_tmo == 8'd0) begin
                        r_cs_n      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_DONE;
`endif
                    end else begin
                        if (rwds_in) begin
                            r_rdata <= w_rdata_next;
                            r_nbyte <= r_nbyte + 2'd1;
                        end
`ifdef HB_RWDS_TIMEOUT_EN
                        r_tmo <= r_tmo - 8'd1;
`endif
                    end
                end
                S_DONE: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign cs_n      = r_cs_n;
    assign dq_out    = r_dq_out;
    assign dq_oe     = r_dq_oe;
    assign rwds_out  = 1'b0;
    assign rwds_oe   = r_rwds_oe;

endmodule

// File: tb/tb_hyperbus_txn_ctrl.sv
// Bench for hyperbus_txn_ctrl: directed and randomized transactions checked
// cycle by cycle against a timeline model derived from the bus protocol.
module tb_hyperbus_txn_ctrl;

    localparam int LAT = 6;
    localparam int TMO = 64;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        cs_n;
    logic [7:0]  dq_out;
    logic        dq_oe;
    logic [7:0]  dq_in;
    logic        rwds_out;
    logic        rwds_oe;
    logic        rwds_in;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    hyperbus_txn_ctrl #(.LATENCY(LAT), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .cs_n      (cs_n),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .dq_in     (dq_in),
        .rwds_out  (rwds_out),
        .rwds_oe   (rwds_oe),
        .rwds_in   (rwds_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte i (0 = first on the bus) of the command-address word, computed arithmetically.
    function automatic logic [7:0] ca_byte(input bit wr, input logic [31:0] a, input int i);
        logic [47:0] w;
        w = ((wr ? 48'd0 : 48'd1) << 47) | (48'd1 << 45)
            | (48'(a >> 3) << 16) | 48'(a & 32'd7);
        return 8'(w >> (8 * (5 - i)));
    endfunction

    function automatic logic [7:0] word_byte(input logic [31:0] d, input int i);
        return 8'(d >> (8 * (3 - i)));
    endfunction

    task automatic check_idle_reset_values(input string tag);
        chk({tag, "_cs_n"}, 32'(cs_n), 32'd1);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_dq_oe"}, 32'(dq_oe), 32'd0);
        chk({tag, "_dq_out"}, 32'(dq_out), 32'd0);
        chk({tag, "_rwds_oe"}, 32'(rwds_oe), 32'd0);
        chk({tag, "_rwds_out"}, 32'(rwds_out), 32'd0);
    endtask

    // Called right after an edge that sampled rst_n=0: release and expect ready one clock later.
    task automatic release_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready_before_edge", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_ready_after_edge", 32'(req_ready), 32'd1);
        chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rel_cs_n", 32'(cs_n), 32'd1);
    endtask

    // One full transaction; w0..w3 are rwds_in=0 wait cycles ahead of each read byte.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int w0, input int w1,
                           input int w2, input int w3);
        bit          rw_q[$];
        logic [7:0]  by_q[$];
        int          waits[4];
        int          d_cyc;
        int          n_cyc;
        bit          tmo_hit;
        int          di;
        waits[0] = w0; waits[1] = w1; waits[2] = w2; waits[3] = w3;
        tmo_hit = 1'b0;
        if (wr) begin
            d_cyc = 4;
        end else begin
            for (int b = 0; b < 4; b++) begin
                for (int j = 0; j < waits[b]; j++) begin
                    rw_q.push_back(1'b0);
                    by_q.push_back(8'($urandom));
                end
                rw_q.push_back(1'b1);
                by_q.push_back(word_byte(rdata, b));
            end
`ifdef HB_RWDS_TIMEOUT_EN
            if (rw_q.size() > TMO) begin
                tmo_hit = 1'b1;
                while (rw_q.size() > TMO) begin
                    void'(rw_q.pop_back());
                    void'(by_q.pop_back());
                end
            end
`endif
            d_cyc = rw_q.size();
        end
        n_cyc = 6 + LAT + d_cyc + 1;

        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        rwds_in   = 1'($urandom);
        dq_in     = 8'($urandom);
        @(negedge clk);
        chk("accept_ready", 32'(req_ready), 32'd1);
        chk("accept_cs_n", 32'(cs_n), 32'd1);

        for (int k = 1; k <= n_cyc; k++) begin
            @(posedge clk); #1;
            req_valid = (k == n_cyc) ? 1'b0 : 1'($urandom);
            req_write = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            di = k - 7 - LAT;
            if (!wr && di >= 0 && di < d_cyc) begin
                rwds_in = rw_q[di];
                dq_in   = by_q[di];
            end else begin
                rwds_in = 1'($urandom);
                dq_in   = 8'($urandom);
            end
            @(negedge clk);
            chk("ready_busy", 32'(req_ready), 32'd0);
            chk("rwds_out", 32'(rwds_out), 32'd0);
            chk("rsp_valid", 32'(rsp_valid), 32'(k == n_cyc));
            if (k <= 6) begin
                chk("ca_cs_n", 32'(cs_n), 32'd0);
                chk("ca_dq_oe", 32'(dq_oe), 32'd1);
                chk("ca_rwds_oe", 32'(rwds_oe), 32'd0);
                chk("ca_byte", 32'(dq_out), 32'(ca_byte(wr, addr, k - 1)));
            end else if (k <= 6 + LAT) begin
                chk("lat_cs_n", 32'(cs_n), 32'd0);
                chk("lat_dq_oe", 32'(dq_oe), 32'd0);
                chk("lat_rwds_oe", 32'(rwds_oe), 32'd0);
            end else if (k < n_cyc) begin
                chk("data_cs_n", 32'(cs_n), 32'd0);
                chk("data_dq_oe", 32'(dq_oe), 32'(wr));
                chk("data_rwds_oe", 32'(rwds_oe), 32'(wr));
                if (wr) chk("wr_byte", 32'(dq_out), 32'(word_byte(wdata, di)));
            end else begin
                chk("done_cs_n", 32'(cs_n), 32'd1);
                chk("done_dq_oe", 32'(dq_oe), 32'd0);
                chk("done_rwds_oe", 32'(rwds_oe), 32'd0);
                chk("done_rdata", rsp_rdata, (wr || tmo_hit) ? 32'd0 : rdata);
                chk("done_err", 32'(rsp_err), 32'(tmo_hit));
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        dq_in     = '0;
        rwds_in   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_reset_values("reset");
        release_reset();

        // Directed: write, plain read, read with a 3-cycle stall before the third byte.
        run_txn(1'b1, 32'h0000_0010, 32'hA5A5_1234, 32'h0, 0, 0, 0, 0);
        run_txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        run_txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 3, 0);
        run_txn(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 0, 0, 0, 0);
        run_txn(1'b0, 32'h8000_0007, 32'h0, 32'h0102_0304, 2, 1, 0, 4);

        // Randomized back-to-back traffic.
        for (int t = 0; t < 20; t++) begin
            run_txn(1'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

`ifdef HB_RWDS_TIMEOUT_EN
        run_txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, TMO + 10, 0, 0, 0);
        run_txn(1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, TMO - 4, 0, 0, 0);
`endif

        // Reset asserted in the middle of the latency phase of a write.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0040;
        req_wdata = 32'h1122_3344;
        @(negedge clk);
        chk("abort_accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_in_lat_cs_n", 32'(cs_n), 32'd0);
        chk("abort_in_lat_dq_oe", 32'(dq_oe), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_idle_reset_values("abort");
        release_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
            chk("abort_cs_idle", 32'(cs_n), 32'd1);
        end

        run_txn(1'b0, 32'h1234_5678, 32'h0, 32'h55AA_33CC, 1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
